// File: rtl/mul_unit.sv
// Iterative shift-add multiplier that sits beside the execute stage.
// Operands are converted to sign + magnitude, the magnitudes are multiplied
// one bit per cycle, and the sign is reapplied before the result is released.
module mul_unit #(
    parameter int WIDTH     = 32,
    parameter int IMM_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [1:0]           mul_type,
    input  logic [3:0]           dest_in,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  logic [IMM_WIDTH-1:0] imm,
    output logic                 busy,
    output logic                 mul_release,
    output logic                 write_en,
    output logic [WIDTH-1:0]     result,
    output logic [3:0]           dest_out,
    output logic [3:0]           flags_back
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t               state;
    state_t               state_next;

    logic                 set_flags;
    logic [3:0]           dest_q;
    logic                 sign_a;
    logic                 sign_b;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        counter;

    logic                 accept;
    logic [WIDTH-1:0]     b_sel;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [2*WIDTH-1:0]   prod_fixed;
    logic [WIDTH:0]       upper_bits;
    logic                 ovf;

    // The magnitude of the most negative value is itself, read as unsigned,
    // so the unsigned shift-add below stays exact for that corner.
    assign accept     = (state == IDLE) && start && !abort;
    assign b_sel      = mul_type[0] ? op_b
                                    : {{(WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
    assign abs_a      = op_a[WIDTH-1] ? -op_a : op_a;
    assign abs_b      = b_sel[WIDTH-1] ? -b_sel : b_sel;
    assign prod_fixed = (sign_a ^ sign_b) ? -acc : acc;
    assign upper_bits = prod_fixed[2*WIDTH-1:WIDTH-1];
    assign ovf        = !((&upper_bits) || (~|upper_bits));

    // State register; reset returns to IDLE even mid-operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; abort wins over everything and also
    // suppresses a release that would otherwise happen in DONE.
    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        mul_release = 1'b0;
        write_en    = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (abort) begin
                    state_next = IDLE;
                end else if (counter == CW'(WIDTH-1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                busy       = 1'b1;
                state_next = abort ? IDLE : DONE;
            end
            DONE: begin
                busy        = 1'b1;
                mul_release = !abort;
                write_en    = !abort;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: latch operands on accept, one shift-add step per RUN cycle,
    // then sign fix-up and result/flag capture on the way into DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            set_flags  <= 1'b0;
            dest_q     <= '0;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            mag_a      <= '0;
            mag_b      <= '0;
            acc        <= '0;
            counter    <= '0;
            result     <= '0;
            dest_out   <= '0;
            flags_back <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        set_flags <= mul_type[1];
                        dest_q    <= dest_in;
                        sign_a    <= op_a[WIDTH-1];
                        sign_b    <= b_sel[WIDTH-1];
                        mag_a     <= abs_a;
                        mag_b     <= abs_b;
                        acc       <= '0;
                        counter   <= '0;
                    end
                end
                RUN: begin
                    if (mag_b[0]) begin
                        acc <= acc + ({{WIDTH{1'b0}}, mag_a} << counter);
                    end
                    mag_b   <= mag_b >> 1;
                    counter <= counter + 1'b1;
                end
                FIX: begin
                    if (!abort) begin
                        acc      <= prod_fixed;
                        result   <= prod_fixed[WIDTH-1:0];
                        dest_out <= dest_q;
                        if (set_flags) begin
                            flags_back <= {prod_fixed[WIDTH-1],
                                           (prod_fixed[WIDTH-1:0] == '0),
                                           1'b0,
                                           ovf};
                        end else begin
                            flags_back <= 4'b0000;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
